// File: rtl/akuma_controller.sv
// Akuma player-character controller: frame-paced stand/punch/jump FSM with
// clamped horizontal movement, driven by a USB HID keycode and a VGA frame strobe.
module akuma_controller #(
  parameter logic        [9:0] X_START      = 10'd100,
  parameter logic        [9:0] GROUND_Y     = 10'd300,
  parameter logic        [9:0] X_MAX        = 10'd576,
  parameter logic        [9:0] STEP         = 10'd2,
  parameter logic        [4:0] PUNCH_FRAMES = 5'd12,
  parameter logic signed [5:0] JUMP_V0      = 6'sd12
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [7:0] keycode,
  output logic [9:0] AkumaX,
  output logic [9:0] AkumaY,
  output logic [2:0] sprite,
  output logic       busy
);

  localparam int unsigned XW  = 10;
  localparam int unsigned CW  = 5;
  localparam int unsigned VW  = 6;
  localparam int unsigned YSW = 11;

  localparam logic [7:0] KEY_W = 8'h1A;
  localparam logic [7:0] KEY_J = 8'h0D;
  localparam logic [7:0] KEY_A = 8'h04;
  localparam logic [7:0] KEY_D = 8'h07;

  typedef enum logic [1:0] {STAND, PUNCH, JUMP} state_t;

  state_t                state, state_d;
  logic [XW-1:0]         x_d, y_d;
  logic signed [VW-1:0]  vy, vy_d;
  logic [CW-1:0]         cnt, cnt_d;
  logic                  armed, armed_d;
  logic [2:0]            sprite_d;

  logic sync1, sync2, sync3;
  logic fill1, fill2, primed;
  logic tick;

  // frame_clk synchroniser; primed blocks a false edge when frame_clk is already high at reset release
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      sync3  <= 1'b0;
      fill1  <= 1'b0;
      fill2  <= 1'b0;
      primed <= 1'b0;
    end else begin
      sync1  <= frame_clk;
      sync2  <= sync1;
      sync3  <= sync2;
      fill1  <= 1'b1;
      fill2  <= fill1;
      primed <= primed | (fill2 & ~sync2);
    end
  end

  assign tick = sync2 & ~sync3 & primed;

  logic [XW-1:0]         x_left, x_right;
  logic [XW:0]           x_right_sum;
  logic signed [YSW-1:0] y_next;
  logic                  land;

  assign x_left      = (AkumaX < STEP) ? '0 : XW'(AkumaX - STEP);
  assign x_right_sum = {1'b0, AkumaX} + {1'b0, STEP};
  assign x_right     = (x_right_sum > {1'b0, X_MAX}) ? X_MAX : x_right_sum[XW-1:0];
  assign y_next      = $signed({1'b0, AkumaY}) - $signed({{(YSW-VW){vy[VW-1]}}, vy});
  assign land        = (y_next >= $signed({1'b0, GROUND_Y}));

  // next-state and datapath updates, all gated by the frame tick
  always_comb begin
    state_d  = state;
    x_d      = AkumaX;
    y_d      = AkumaY;
    vy_d     = vy;
    cnt_d    = cnt;
    armed_d  = armed;
    sprite_d = 3'd0;
    if (tick) begin
      if (keycode != KEY_J) armed_d = 1'b1;
      case (state)
        STAND: begin
          y_d = GROUND_Y;
          if (keycode == KEY_W) begin
            state_d = JUMP;
            vy_d    = JUMP_V0;
          end else if (keycode == KEY_J && armed) begin
            state_d = PUNCH;
            cnt_d   = CW'(PUNCH_FRAMES - 5'd1);
            armed_d = 1'b0;
          end else if (keycode == KEY_A) begin
            x_d = x_left;
          end else if (keycode == KEY_D) begin
            x_d = x_right;
          end
        end
        PUNCH: begin
          if (cnt == '0) state_d = STAND;
          else           cnt_d   = CW'(cnt - 5'd1);
        end
        JUMP: begin
          if (keycode == KEY_A)      x_d = x_left;
          else if (keycode == KEY_D) x_d = x_right;
          if (land) begin
            y_d     = GROUND_Y;
            vy_d    = '0;
            state_d = STAND;
          end else begin
            y_d  = y_next[XW-1:0];
            vy_d = VW'(vy - 6'sd1);
          end
        end
        default: state_d = STAND;
      endcase
    end
    case (state_d)
      PUNCH:   sprite_d = 3'd1;
      JUMP:    sprite_d = 3'd2;
      default: sprite_d = 3'd0;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state  <= STAND;
      AkumaX <= X_START;
      AkumaY <= GROUND_Y;
      vy     <= '0;
      cnt    <= '0;
      armed  <= 1'b1;
      sprite <= 3'd0;
    end else begin
      state  <= state_d;
      AkumaX <= x_d;
      AkumaY <= y_d;
      vy     <= vy_d;
      cnt    <= cnt_d;
      armed  <= armed_d;
      sprite <= sprite_d;
    end
  end

  assign busy = (state != STAND);

endmodule

// File: tb/tb_akuma_controller.sv
// Scoreboard bench for akuma_controller: stimulus queues expected poses per
// frame_clk pulse, a monitor checks hold-until-3rd-edge and the updated pose.
`timescale 1ns/1ps
module tb_akuma_controller;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [2:0] sprite;
    logic       busy;
  } obs_t;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_clk = 1'b0;
  logic [7:0] keycode = 8'h00;
  logic [9:0] AkumaX, AkumaY;
  logic [2:0] sprite;
  logic       busy;

  int    n_cmp = 0;
  int    n_bad = 0;
  obs_t  exp_q[$];
  string name_q[$];
  obs_t  last;

  int jy [0:25] = '{300, 288, 277, 267, 258, 250, 243, 237, 232, 228, 225, 223, 222,
                    222, 223, 225, 228, 232, 237, 243, 250, 258, 267, 277, 288, 300};

  akuma_controller dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .frame_clk (frame_clk),
    .keycode   (keycode),
    .AkumaX    (AkumaX),
    .AkumaY    (AkumaY),
    .sprite    (sprite),
    .busy      (busy)
  );

  always #5 Clk = ~Clk;

  function automatic obs_t mk(input int x, input int y, input int sp);
    obs_t o;
    o.x      = 10'(x);
    o.y      = 10'(y);
    o.sprite = 3'(sp);
    o.busy   = (sp != 0);
    return o;
  endfunction

  function automatic obs_t dut_obs();
    obs_t o;
    o.x      = AkumaX;
    o.y      = AkumaY;
    o.sprite = sprite;
    o.busy   = busy;
    return o;
  endfunction

  task automatic compare(input string nm, input obs_t got, input obs_t want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got x=%0d y=%0d sprite=%0d busy=%0d, expected x=%0d y=%0d sprite=%0d busy=%0d",
               nm, got.x, got.y, got.sprite, got.busy, want.x, want.y, want.sprite, want.busy);
    end
  endtask

  // one frame strobe, raised between clock edges to stay asynchronous to Clk
  task automatic pulse(input logic [7:0] key, input obs_t want, input string nm);
    keycode = key;
    exp_q.push_back(want);
    name_q.push_back(nm);
    @(negedge Clk);
    frame_clk = 1'b1;
    repeat (4) @(posedge Clk);
    #3 frame_clk = 1'b0;
    repeat (4) @(posedge Clk);
    #2;
  endtask

  task automatic do_reset();
    keycode   = 8'h00;
    frame_clk = 1'b0;
    Reset     = 1'b1;
    #12;
    compare("reset_values", dut_obs(), mk(100, 300, 0));
    @(negedge Clk);
    Reset = 1'b0;
    last  = mk(100, 300, 0);
    repeat (3) @(posedge Clk);
    #2;
  endtask

  // monitor: outputs must hold through the 2nd edge and update on the 3rd
  initial begin
    forever begin
      obs_t  want;
      string nm;
      @(posedge frame_clk);
      if (!Reset && exp_q.size() > 0) begin
        repeat (2) @(posedge Clk);
        #1;
        compare({name_q[0], "_hold"}, dut_obs(), last);
        @(posedge Clk);
        #1;
        want = exp_q.pop_front();
        nm   = name_q.pop_front();
        compare(nm, dut_obs(), want);
        last = want;
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    last = mk(100, 300, 0);
    do_reset();

    for (int i = 1; i <= 10; i++)
      pulse(8'h07, mk(100 + 2 * i, 300, 0), $sformatf("walk_d_%0d", i));

    do_reset();
    for (int i = 1; i <= 60; i++)
      pulse(8'h04, mk((i >= 50) ? 0 : 100 - 2 * i, 300, 0), $sformatf("walk_a_%0d", i));
    for (int i = 1; i <= 292; i++)
      pulse(8'h07, mk((2 * i >= 576) ? 576 : 2 * i, 300, 0), $sformatf("clamp_d_%0d", i));

    do_reset();
    for (int i = 1; i <= 40; i++)
      pulse(8'h0D, mk(100, 300, (i <= 12) ? 1 : 0), $sformatf("punch_hold_%0d", i));
    pulse(8'h00, mk(100, 300, 0), "punch_release");
    pulse(8'h0D, mk(100, 300, 1), "punch_rearmed");
    for (int k = 1; k <= 12; k++)
      pulse(8'h04, mk(100, 300, (k < 12) ? 1 : 0), $sformatf("punch_nomove_%0d", k));

    do_reset();
    pulse(8'h1A, mk(100, 300, 2), "jump_start");
    for (int k = 1; k <= 25; k++)
      pulse(8'h00, mk(100, jy[k], (k < 25) ? 2 : 0), $sformatf("jump_%0d", k));
    pulse(8'h1A, mk(100, 300, 2), "jump2_start");
    for (int k = 1; k <= 25; k++)
      pulse(8'h07, mk(100 + 2 * k, jy[k], (k < 25) ? 2 : 0), $sformatf("jump2_d_%0d", k));

    pulse(8'h1A, mk(150, 300, 2), "jump3_start");
    for (int k = 1; k <= 5; k++)
      pulse(8'h00, mk(150, jy[k], 2), $sformatf("jump3_%0d", k));
    #2 Reset = 1'b1;
    #1 compare("reset_mid_jump", dut_obs(), mk(100, 300, 0));
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    last  = mk(100, 300, 0);

    repeat (2) @(posedge Clk);
    Reset     = 1'b1;
    frame_clk = 1'b1;
    keycode   = 8'h07;
    #20;
    @(negedge Clk);
    Reset = 1'b0;
    repeat (6) @(posedge Clk);
    #1 compare("no_tick_on_release", dut_obs(), mk(100, 300, 0));
    frame_clk = 1'b0;
    repeat (4) @(posedge Clk);
    #2;
    pulse(8'h07, mk(102, 300, 0), "first_after_release");

    for (int t = 0; t < 20 && exp_q.size() > 0; t++) @(posedge Clk);
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expected responses left, required 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/akuma_controller.md
AKUMA_CONTROLLER -- requirements
Module: akuma_controller

Interface
REQ-001 Parameter X_START, default 10'd100, reset horizontal position.
REQ-002 Parameter GROUND_Y, default 10'd300, standing vertical position.
REQ-003 Parameter X_MAX, default 10'd576, rightmost legal AkumaX (640 minus 64-pixel sprite width).
REQ-004 Parameter STEP, default 10'd2, horizontal pixels per frame.
REQ-005 Parameter PUNCH_FRAMES, default 5'd12, frames spent in punch.
REQ-006 Parameter JUMP_V0, default 6'sd12, initial upward velocity, pixels/frame.
REQ-007 Clk  input  1  single system clock; all flops on rising edge.
REQ-008 Reset  input  1  asynchronous, active-high reset.
REQ-009 frame_clk  input  1  VGA vertical-sync-derived frame strobe, asynchronous to Clk.
REQ-010 keycode  input  8  current USB HID keycode; 8'h00 means no key.
REQ-011 AkumaX  output  10  sprite left edge, registered.
REQ-012 AkumaY  output  10  sprite top edge, registered.
REQ-013 sprite  output  3  pose code driving the sprite selector: 0 standing, 1 punching, 2 jumping.
REQ-014 busy  output  1  high while in PUNCH or JUMP.

Function
REQ-015 frame_clk SHALL pass a 2-flop synchroniser plus one delay flop; tick = sync2 & ~sync3, high exactly one Clk cycle per frame_clk rising edge.
REQ-016 All state, position, velocity and counter updates SHALL occur only on Clk edges where tick=1; outputs update on the 3rd Clk edge after frame_clk rises.
REQ-017 FSM states SHALL be STAND, PUNCH, JUMP; sprite SHALL equal 0/1/2 respectively, registered with state.
REQ-018 STAND on tick, priority order: keycode 8'h1A (W) -> JUMP with vy=JUMP_V0; else 8'h0D (J) with punch_armed=1 -> PUNCH, counter=PUNCH_FRAMES-1, punch_armed=0; else 8'h04 (A) move left; else 8'h07 (D) move right; else hold.
REQ-019 punch_armed SHALL set on any tick where keycode != 8'h0D; holding J yields exactly one punch.
REQ-020 PUNCH: no movement; counter decrements per tick; tick with counter=0 -> STAND; total PUNCH_FRAMES ticks in PUNCH.
REQ-021 JUMP on tick: next_y = AkumaY - vy (11-bit signed compute); vy = vy - 1 (6-bit signed); A/D move horizontally as in STAND; W/J ignored.
REQ-022 JUMP landing: if next_y >= GROUND_Y, AkumaY = GROUND_Y, vy = 0, state -> STAND on that tick.
REQ-023 Left move: AkumaX < STEP -> AkumaX = 0, else AkumaX - STEP; right move: AkumaX + STEP > X_MAX -> AkumaX = X_MAX, else AkumaX + STEP.
REQ-024 AkumaY SHALL equal GROUND_Y in STAND and PUNCH; never below GROUND_Y.
REQ-025 Unrecognised keycodes SHALL act as no key (punch re-arm included).
REQ-026 busy SHALL be combinational decode of registered state (no added latency).

Reset
REQ-027 Reset SHALL asynchronously force AkumaX=X_START, AkumaY=GROUND_Y, sprite=0, state=STAND, busy=0, vy=0, counter=0, punch_armed=1, synchroniser flops=0.
REQ-028 Reset asserted mid-PUNCH or mid-JUMP SHALL abort immediately to REQ-027 values; no tick generated on release with frame_clk already high until its next rising edge.

Verification
REQ-029 Reset, keycode=8'h07, 10 frame_clk pulses -> AkumaX=120, AkumaY=300, sprite=0 throughout.
REQ-030 keycode=8'h04 from reset, 60 pulses -> AkumaX clamps at 0 after pulse 50, stays 0; symmetric D test clamps at 576.
REQ-031 keycode=8'h0D held 40 pulses -> sprite=1, busy=1 for exactly 12 ticks, then sprite=0 and no second punch until keycode released for one tick.
REQ-032 keycode=8'h1A one pulse then 8'h00 -> AkumaY sequence 288,277,267,... apex 222, returns to 300 with sprite=0 after 25 ticks.
REQ-033 Reset asserted mid-jump (AkumaY=250) -> next Clk-independent outputs X=100, Y=300, sprite=0, busy=0.
REQ-034 frame_clk toggled with keycode=8'h07 while checking tick -> exactly one 2-pixel step per frame_clk rising edge, output change on 3rd Clk edge.
